// File: rtl/hit_scan_ctrl.sv
// Per-frame bullet-vs-player hit scheduler: walks the bullet table once per frame,
// time-sharing one registered hit checker, and turns hits into kill and life-loss events.
module hit_scan_ctrl #(
    parameter int NUM_BULLETS   = 8,
    parameter int IDX_W         = 3,
    parameter int CHK_LAT       = 2,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [9:0]       my_x,
    input  logic [8:0]       my_y,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [9:0]       bul_x,
    input  logic [8:0]       bul_y,
    input  logic             bul_valid,
    output logic [9:0]       chk_ebi_x,
    output logic [8:0]       chk_ebi_y,
    output logic [9:0]       chk_mi_x,
    output logic [8:0]       chk_mi_y,
    input  logic             chk_hit,
    output logic             kill_req,
    output logic [IDX_W-1:0] kill_idx,
    output logic             player_hit,
    output logic [2:0]       lives,
    output logic             invuln,
    output logic             scan_busy,
    output logic             scan_done,
    output logic             game_over,
    output logic             overrun
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam int               WAIT_W   = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
    localparam int               INV_W    = $clog2(INVULN_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BULLETS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   slot;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [INV_W-1:0]   inv_cnt;
    logic               v_q;
    logic               start;
    logic               hit;
    logic               take_life;

    assign start     = (state == IDLE) && frame_start && !game_over;
    assign hit       = (state == SAMPLE) && v_q && chk_hit;
    assign take_life = hit && (inv_cnt == '0) && (lives != '0);
    assign rd_idx    = slot;
    assign invuln    = (inv_cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        scan_busy = 1'b1;
        scan_done = 1'b0;
        case (state)
            IDLE: begin
                scan_busy = 1'b0;
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                rd_en     = 1'b1;
                state_nxt = LOAD;
            end
            LOAD:   state_nxt = WAIT;
            WAIT:   if (wait_cnt == '0) state_nxt = SAMPLE;
            SAMPLE: state_nxt = (slot == LAST_IDX) ? DONE : FETCH;
            DONE: begin
                scan_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: reset clears every register here, including the datapath copies;
    // this block holds flops only, no storage arrays.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= '0;
            kill_idx   <= '0;
            kill_req   <= 1'b0;
            player_hit <= 1'b0;
            chk_ebi_x  <= '0;
            chk_ebi_y  <= '0;
            chk_mi_x   <= '0;
            chk_mi_y   <= '0;
            v_q        <= 1'b0;
            wait_cnt   <= '0;
            inv_cnt    <= '0;
            lives      <= 3'(LIVES_INIT);
            game_over  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            kill_req   <= 1'b0;
            player_hit <= 1'b0;
            // A frame arriving mid-scan (DONE included) is dropped but remembered.
            if (frame_start && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        chk_mi_x <= my_x;
                        chk_mi_y <= my_y;
                        slot     <= '0;
                        if (inv_cnt != '0) inv_cnt <= inv_cnt - INV_W'(1);
                    end
                end
                LOAD: begin
                    chk_ebi_x <= bul_x;
                    chk_ebi_y <= bul_y;
                    v_q       <= bul_valid;
                    wait_cnt  <= WAIT_W'(CHK_LAT - 1);
                end
                WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                SAMPLE: begin
                    if (hit) begin
                        kill_req <= 1'b1;
                        kill_idx <= slot;
                    end
                    // Only the first unprotected hit costs a life; the reload shields the rest.
                    if (take_life) begin
                        player_hit <= 1'b1;
                        lives      <= lives - 3'd1;
                        inv_cnt    <= INV_W'(INVULN_FRAMES);
                        if (lives == 3'd1) game_over <= 1'b1;
                    end
                    if (slot != LAST_IDX) slot <= slot + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hit_scan_ctrl.sv
// Self-checking bench for hit_scan_ctrl: bullet-table and checker models plus a
// frame-level reference of kills, lives, invulnerability and game-over.
module tb_hit_scan_ctrl;

    localparam int NB     = 8;
    localparam int LAT    = 2;
    localparam int SLOT_T = LAT + 3;
    localparam int DONE_C = NB * SLOT_T + 1;
    localparam int INV_F  = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] my_x = '0;
    logic [8:0] my_y = '0;
    logic       rd_en;
    logic [2:0] rd_idx;
    logic [9:0] bul_x = '0;
    logic [8:0] bul_y = '0;
    logic       bul_valid = 1'b0;
    logic [9:0] chk_ebi_x;
    logic [8:0] chk_ebi_y;
    logic [9:0] chk_mi_x;
    logic [8:0] chk_mi_y;
    logic       chk_hit;
    logic       kill_req;
    logic [2:0] kill_idx;
    logic       player_hit;
    logic [2:0] lives;
    logic       invuln;
    logic       scan_busy;
    logic       scan_done;
    logic       game_over;
    logic       overrun;

    hit_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .my_x       (my_x),
        .my_y       (my_y),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .bul_x      (bul_x),
        .bul_y      (bul_y),
        .bul_valid  (bul_valid),
        .chk_ebi_x  (chk_ebi_x),
        .chk_ebi_y  (chk_ebi_y),
        .chk_mi_x   (chk_mi_x),
        .chk_mi_y   (chk_mi_y),
        .chk_hit    (chk_hit),
        .kill_req   (kill_req),
        .kill_idx   (kill_idx),
        .player_hit (player_hit),
        .lives      (lives),
        .invuln     (invuln),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .game_over  (game_over),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Bullet table contents for the current frame and the player position.
    int tbl_x[NB];
    int tbl_y[NB];
    bit tbl_v[NB];
    int px;
    int py;

    // Frame-level reference state.
    int m_lives = 3;
    int m_inv   = 0;
    bit m_go    = 1'b0;
    bit m_ovr   = 1'b0;

    function automatic bit overlap(int bx, int by, int ax, int ay);
        int dx = bx - ax;
        int dy = by - ay;
        return (dx < 16) && (dx > -16) && (dy < 16) && (dy > -16);
    endfunction

    // Registered table read; garbage outside the read cycle exposes timing slips.
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    always @(posedge clk) begin
        if (rd_en) begin
            bul_x     <= 10'(tbl_x[rd_idx]);
            bul_y     <= 9'(tbl_y[rd_idx]);
            bul_valid <= tbl_v[rd_idx];
        end else begin
            bul_x     <= 10'($urandom);
            bul_y     <= 9'($urandom);
            bul_valid <= 1'($urandom);
        end
        p1 <= overlap(int'(chk_ebi_x), int'(chk_ebi_y), int'(chk_mi_x), int'(chk_mi_y));
        p2 <= p1;
    end
    assign chk_hit = p2;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".lives"}, int'(lives), 3);
        check({tag, ".invuln"}, int'(invuln), 0);
        check({tag, ".busy"}, int'(scan_busy), 0);
        check({tag, ".done"}, int'(scan_done), 0);
        check({tag, ".rd_en"}, int'(rd_en), 0);
        check({tag, ".rd_idx"}, int'(rd_idx), 0);
        check({tag, ".kill_req"}, int'(kill_req), 0);
        check({tag, ".kill_idx"}, int'(kill_idx), 0);
        check({tag, ".player_hit"}, int'(player_hit), 0);
        check({tag, ".game_over"}, int'(game_over), 0);
        check({tag, ".overrun"}, int'(overrun), 0);
        check({tag, ".chk"}, int'({chk_ebi_x, chk_ebi_y, chk_mi_x, chk_mi_y} != '0), 0);
    endtask

    task automatic model_reset();
        m_lives = 3;
        m_inv   = 0;
        m_go    = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic new_player();
        px = int'($urandom_range(40, 800));
        py = int'($urandom_range(40, 400));
    endtask

    // Valid slots in hmask sit on the player; other slots are far away in x.
    task automatic set_table(input logic [7:0] vmask, input logic [7:0] hmask);
        new_player();
        for (int s = 0; s < NB; s++) begin
            tbl_v[s] = vmask[s];
            if (hmask[s]) begin
                tbl_x[s] = px + int'($urandom_range(0, 10)) - 5;
                tbl_y[s] = py + int'($urandom_range(0, 10)) - 5;
            end else begin
                tbl_x[s] = (px >= 420) ? px - 300 : px + 300;
                tbl_y[s] = int'($urandom_range(0, 511));
            end
        end
    endtask

    task automatic random_table();
        new_player();
        for (int s = 0; s < NB; s++) begin
            tbl_v[s] = 1'($urandom);
            tbl_x[s] = px + int'($urandom_range(0, 40)) - 20;
            tbl_y[s] = py + int'($urandom_range(0, 40)) - 20;
        end
    endtask

    // Runs one frame. extra_fs: cycle of a second frame_start (-1 none);
    // rst_at: cycle in which rst is asserted (-1 none).
    task automatic run_frame(input int extra_fs, input int rst_at);
        int limit;
        bit active;
        int exp_kidx[$];
        int exp_kcyc[$];
        int exp_ph_cnt;
        int exp_ph_cyc;
        int exp_rd;
        int exp_done;
        int got_kidx[$];
        int got_kcyc[$];
        int rd_cnt   = 0;
        int seq_err  = 0;
        int done_cyc = -1;
        int ph_cnt   = 0;
        int ph_cyc   = -1;
        int mi_err   = 0;
        int busy_err = 0;
        int go_err   = 0;

        limit      = (rst_at > 0) ? rst_at : 1000;
        active     = !m_go;
        exp_ph_cnt = 0;
        exp_ph_cyc = -1;
        exp_rd     = 0;
        exp_done   = -1;
        if (active) begin
            if (m_inv > 0) m_inv--;
            for (int s = 0; s < NB; s++) begin
                if (tbl_v[s] && overlap(tbl_x[s], tbl_y[s], px, py)) begin
                    int kc = 1 + SLOT_T * (s + 1);
                    if (kc <= limit) begin
                        exp_kidx.push_back(s);
                        exp_kcyc.push_back(kc);
                    end
                    if (m_inv == 0 && m_lives > 0) begin
                        m_lives--;
                        m_inv = INV_F;
                        if (m_lives == 0) m_go = 1'b1;
                        if (kc <= limit) begin
                            exp_ph_cnt++;
                            exp_ph_cyc = kc;
                        end
                    end
                end
            end
            for (int k = 0; k < NB; k++) if (1 + SLOT_T * k <= limit) exp_rd++;
            if (DONE_C <= limit) exp_done = DONE_C;
            if (extra_fs >= 1 && extra_fs <= DONE_C) m_ovr = 1'b1;
        end

        @(negedge clk);
        my_x        = 10'(px);
        my_y        = 9'(py);
        frame_start = 1'b1;
        for (int c = 1; c <= DONE_C + 5; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            my_x        = 10'($urandom);
            my_y        = 9'($urandom);
            if (rst_at > 0 && c == rst_at + 1) begin
                check_reset_state("abort");
                rst = 1'b0;
            end
            if (rd_en) begin
                if (int'(rd_idx) != rd_cnt || c != 1 + SLOT_T * rd_cnt) seq_err++;
                rd_cnt++;
            end
            if (kill_req) begin
                got_kidx.push_back(int'(kill_idx));
                got_kcyc.push_back(c);
            end
            if (player_hit) begin
                ph_cnt++;
                ph_cyc = c;
                if (game_over != (lives == 3'd0)) go_err++;
            end
            if (scan_done && done_cyc < 0) done_cyc = c;
            if (active && c <= DONE_C && c <= limit &&
                (int'(chk_mi_x) != px || int'(chk_mi_y) != py)) mi_err++;
            if (scan_busy != (active && c <= DONE_C && c <= limit)) busy_err++;
            if (c == extra_fs) frame_start = 1'b1;
            if (c == rst_at) rst = 1'b1;
        end

        if (rst_at > 0) model_reset();
        check("rd_count", rd_cnt, exp_rd);
        check("rd_sequence_errors", seq_err, 0);
        check("scan_done_cycle", done_cyc, exp_done);
        check("kill_count", got_kidx.size(), exp_kidx.size());
        for (int k = 0; k < got_kidx.size() && k < exp_kidx.size(); k++) begin
            check("kill_idx", got_kidx[k], exp_kidx[k]);
            check("kill_cycle", got_kcyc[k], exp_kcyc[k]);
        end
        check("player_hit_count", ph_cnt, exp_ph_cnt);
        if (exp_ph_cnt > 0) check("player_hit_cycle", ph_cyc, exp_ph_cyc);
        check("game_over_with_hit", go_err, 0);
        check("chk_mi_hold_errors", mi_err, 0);
        check("scan_busy_errors", busy_err, 0);
        check("lives", int'(lives), m_lives);
        check("invuln", int'(invuln), int'(m_inv != 0));
        check("game_over", int'(game_over), int'(m_go));
        check("overrun", int'(overrun), int'(m_ovr));
    endtask

    initial begin
        int guard;
        do_reset();

        // Occupied-looking positions but all slots empty: nothing may hit.
        set_table(8'h00, 8'hFF);
        run_frame(-1, -1);

        // Slot 3 hits, other valid slots miss.
        set_table(8'h8B, 8'h08);
        run_frame(-1, -1);

        // Two hits in one scan cost a single life.
        do_reset();
        set_table(8'h24 | 8'($urandom), 8'h24);
        run_frame(-1, -1);

        // Hits during the 59 protected frames only kill; the 60th frame costs a life.
        for (int f = 0; f < INV_F; f++) begin
            set_table(8'h01 << $urandom_range(0, 7), 8'hFF);
            run_frame(-1, -1);
        end

        // Random play until the lives run out, then confirm frames are ignored.
        for (int f = 0; f < 70; f++) begin
            random_table();
            run_frame(-1, -1);
        end
        guard = 0;
        while (!m_go && guard < 150) begin
            set_table(8'hFF, 8'hFF);
            run_frame(-1, -1);
            guard++;
        end
        set_table(8'hFF, 8'hFF);
        run_frame(-1, -1);

        // Stray frame_start mid-scan and coincident with DONE.
        do_reset();
        set_table(8'h00, 8'h00);
        run_frame(10, -1);
        set_table(8'h00, 8'h00);
        run_frame(DONE_C, -1);

        // Reset during slot 3 SAMPLE suppresses its kill.
        do_reset();
        set_table(8'h08, 8'h08);
        run_frame(-1, 4 * SLOT_T);
        random_table();
        run_frame(-1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
